// File: rtl/clock_set_ctrl_if.sv
// Bus between the clock-setting front end and the minute/hour counters:
// live time in, load strobe with new hh:mm and tick inhibit out.
interface clock_set_ctrl_if;
    logic [6:0] cur_minutes;
    logic [5:0] cur_hours;
    logic       time_load;
    logic [6:0] load_minutes;
    logic [5:0] load_hours;
    logic       tick_inhibit;

    modport master (
        input  cur_minutes, cur_hours,
        output time_load, load_minutes, load_hours, tick_inhibit
    );

    modport slave (
        output cur_minutes, cur_hours,
        input  time_load, load_minutes, load_hours, tick_inhibit
    );
endinterface

// File: rtl/clock_set_ctrl.sv
// Clock user-input front end: button debounce and auto-repeat, time/alarm
// setting FSM, commit strobe to the time counters and digit blink.
module clock_set_ctrl #(
    parameter int DEBOUNCE_CYCLES   = 500000,
    parameter int REPEAT_CYCLES     = 10000000,
    parameter int BLINK_HALF_CYCLES = 12500000,
    parameter int ALARM_H_RST       = 7,
    parameter int ALARM_M_RST       = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_mode,
    input  logic             btn_inc,
    clock_set_ctrl_if.master cnt_bus,
    output logic [6:0]       alarm_minutes,
    output logic [5:0]       alarm_hours,
    output logic             alarm_enable,
    output logic [2:0]       edit_state,
    output logic             blink
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int RP_W = $clog2(REPEAT_CYCLES) + 1;
    localparam int BL_W = $clog2(BLINK_HALF_CYCLES) + 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RP_W-1:0] RP_LAST = RP_W'(REPEAT_CYCLES - 1);
    localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_HALF_CYCLES - 1);
    localparam int MODE = 0;
    localparam int INC  = 1;

    typedef enum logic [2:0] {
        RUN   = 3'd0,
        SET_H = 3'd1,
        SET_M = 3'd2,
        AL_H  = 3'd3,
        AL_M  = 3'd4,
        AL_EN = 3'd5
    } state_t;

    logic [1:0]      sync_a, sync_b, level, press;
    logic [DB_W-1:0] db_cnt [2];
    logic [RP_W-1:0] rep_cnt;
    logic            rep_q;
    logic            mode_pulse, inc_pulse, inc_act;
    state_t          state, state_nxt;
    logic [5:0]      edit_h;
    logic [6:0]      edit_m;
    logic [BL_W-1:0] blink_cnt;

    // Bit MODE / INC of each vector belongs to the corresponding button.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a    <= '0;
            sync_b    <= '0;
            level     <= '0;
            press     <= '0;
            db_cnt[0] <= '0;
            db_cnt[1] <= '0;
        end else begin
            // NOTE: non-blocking so sync_b takes the pre-edge sync_a, giving two real flops.
            sync_a <= {btn_inc, btn_mode};
            sync_b <= sync_a;
            for (int b = 0; b < 2; b++) begin
                press[b] <= 1'b0;
                if (sync_b[b] == level[b]) begin
                    db_cnt[b] <= '0;
                end else if (db_cnt[b] == DB_LAST) begin
                    db_cnt[b] <= '0;
                    level[b]  <= sync_b[b];
                    press[b]  <= sync_b[b];
                end else begin
                    db_cnt[b] <= db_cnt[b] + 1'b1;
                end
            end
        end
    end

    // Repeat phase counts from the press cycle; a repeat only counts while still held.
    always_ff @(posedge clk) begin
        if (rst || !level[INC]) begin
            rep_cnt <= '0;
            rep_q   <= 1'b0;
        end else if (rep_cnt == RP_LAST) begin
            rep_cnt <= '0;
            rep_q   <= 1'b1;
        end else begin
            rep_cnt <= rep_cnt + 1'b1;
            rep_q   <= 1'b0;
        end
    end

    assign mode_pulse = press[MODE];
    assign inc_pulse  = press[INC] | (rep_q & level[INC]);
    assign inc_act    = inc_pulse & ~mode_pulse;

    always_comb begin
        // NOTE: default first so no path leaves state_nxt unassigned (no latch).
        state_nxt = state;
        case (state)
            RUN:     if (mode_pulse) state_nxt = SET_H;
            SET_H:   if (mode_pulse) state_nxt = SET_M;
            SET_M:   if (mode_pulse) state_nxt = AL_H;
            AL_H:    if (mode_pulse) state_nxt = AL_M;
            AL_M:    if (mode_pulse) state_nxt = AL_EN;
            AL_EN:   if (mode_pulse) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                <= RUN;
            edit_h               <= '0;
            edit_m               <= '0;
            cnt_bus.time_load    <= 1'b0;
            cnt_bus.load_hours   <= '0;
            cnt_bus.load_minutes <= '0;
            cnt_bus.tick_inhibit <= 1'b0;
            alarm_hours          <= 6'(ALARM_H_RST);
            alarm_minutes        <= 7'(ALARM_M_RST);
            alarm_enable         <= 1'b0;
            blink                <= 1'b1;
            blink_cnt            <= '0;
        end else begin
            state                <= state_nxt;
            cnt_bus.tick_inhibit <= (state_nxt == SET_H) || (state_nxt == SET_M);
            cnt_bus.time_load    <= 1'b0;

            if ((state_nxt != state) || inc_pulse || (state == RUN)) begin
                blink_cnt <= '0;
                blink     <= 1'b1;
            end else if (blink_cnt == BL_LAST) begin
                blink_cnt <= '0;
                blink     <= ~blink;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end

            // Edit values copied from out-of-range live time wrap to 0 on the next inc.
            case (state)
                RUN: if (mode_pulse) begin
                    edit_h <= cnt_bus.cur_hours;
                    edit_m <= cnt_bus.cur_minutes;
                end
                SET_H: if (inc_act)
                    edit_h <= (edit_h >= 6'd23) ? 6'd0 : edit_h + 6'd1;
                SET_M: if (mode_pulse) begin
                    cnt_bus.time_load    <= 1'b1;
                    cnt_bus.load_hours   <= edit_h;
                    cnt_bus.load_minutes <= edit_m;
                end else if (inc_act) begin
                    edit_m <= (edit_m >= 7'd59) ? 7'd0 : edit_m + 7'd1;
                end
                AL_H: if (inc_act)
                    alarm_hours <= (alarm_hours == 6'd23) ? 6'd0 : alarm_hours + 6'd1;
                AL_M: if (inc_act)
                    alarm_minutes <= (alarm_minutes == 7'd59) ? 7'd0 : alarm_minutes + 7'd1;
                AL_EN: if (inc_act)
                    alarm_enable <= ~alarm_enable;
                default: ;
            endcase
        end
    end

    assign edit_state = state;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Self-checking bench for clock_set_ctrl: directed scenarios then random
// button activity, checked against a press-level behavioural model.
module tb_clock_set_ctrl;
    localparam int D = 4;
    localparam int R = 16;
    localparam int B = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_mode;
    logic       btn_inc;
    logic [6:0] alarm_minutes;
    logic [5:0] alarm_hours;
    logic       alarm_enable;
    logic [2:0] edit_state;
    logic       blink;

    clock_set_ctrl_if bus();

    clock_set_ctrl #(
        .DEBOUNCE_CYCLES(D), .REPEAT_CYCLES(R), .BLINK_HALF_CYCLES(B),
        .ALARM_H_RST(7), .ALARM_M_RST(0)
    ) dut (
        .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_inc(btn_inc),
        .cnt_bus(bus.master), .alarm_minutes(alarm_minutes),
        .alarm_hours(alarm_hours), .alarm_enable(alarm_enable),
        .edit_state(edit_state), .blink(blink)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_loads  = 0;

    // Model state: what the clock should be doing, one step per accepted press.
    int m_state, m_eh, m_em, m_ah, m_am, m_en, m_lh, m_lm, exp_loads;
    int cur_h, cur_m;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    endtask

    always @(negedge clk) begin
        if (bus.time_load === 1'b1) begin
            n_loads++;
            check("load_in_al_h", 32'(edit_state), 3);
        end
    end

    function automatic void model_mode();
        case (m_state)
            0: begin m_eh = cur_h; m_em = cur_m; m_state = 1; end
            1: m_state = 2;
            2: begin exp_loads++; m_lh = m_eh; m_lm = m_em; m_state = 3; end
            3: m_state = 4;
            4: m_state = 5;
            default: m_state = 0;
        endcase
    endfunction

    function automatic void model_inc();
        case (m_state)
            1: m_eh = (m_eh >= 23) ? 0 : m_eh + 1;
            2: m_em = (m_em >= 59) ? 0 : m_em + 1;
            3: m_ah = (m_ah == 23) ? 0 : m_ah + 1;
            4: m_am = (m_am == 59) ? 0 : m_am + 1;
            5: m_en = 1 - m_en;
            default: ;
        endcase
    endfunction

    task automatic set_cur(input int h, input int m);
        cur_h = h;
        cur_m = m;
        bus.cur_hours   = 6'(h);
        bus.cur_minutes = 7'(m);
    endtask

    task automatic check_op(input string tag);
        check({tag, "_state"}, 32'(edit_state), m_state);
        check({tag, "_inhibit"}, 32'(bus.tick_inhibit), (m_state == 1 || m_state == 2) ? 1 : 0);
        check({tag, "_al_h"}, 32'(alarm_hours), m_ah);
        check({tag, "_al_m"}, 32'(alarm_minutes), m_am);
        check({tag, "_al_en"}, 32'(alarm_enable), m_en);
        check({tag, "_loads"}, n_loads, exp_loads);
        check({tag, "_load_h"}, 32'(bus.load_hours), m_lh);
        check({tag, "_load_m"}, 32'(bus.load_minutes), m_lm);
    endtask

    // A held level of H cycles gives one press if H >= D, and inc repeats every R while held.
    task automatic press(input bit do_mode, input bit do_inc, input int hold, input string tag);
        @(negedge clk);
        btn_mode = do_mode;
        btn_inc  = do_inc;
        repeat (hold) @(negedge clk);
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        repeat (D + 6) @(negedge clk);
        if (hold >= D) begin
            if (do_mode) model_mode();
            else if (do_inc) repeat ((hold - 1) / R + 1) model_inc();
        end
        check_op(tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        @(negedge clk);
        check({tag, "_state_now"}, 32'(edit_state), 0);
        check({tag, "_inhibit_now"}, 32'(bus.tick_inhibit), 0);
        @(negedge clk);
        rst = 1'b0;
        m_state = 0; m_ah = 7; m_am = 0; m_en = 0; m_lh = 0; m_lm = 0;
        check({tag, "_blink"}, 32'(blink), 1);
        check({tag, "_tload"}, 32'(bus.time_load), 0);
        check_op(tag);
    endtask

    task automatic check_blink(input string tag);
        logic prev;
        int run, ntr;
        prev = blink;
        run = 0;
        ntr = 0;
        for (int i = 0; i < 3 * B + 2; i++) begin
            @(negedge clk);
            if (blink !== prev) begin
                if (ntr > 0) check({tag, "_half_period"}, run, B);
                ntr++;
                run = 1;
            end else begin
                run++;
            end
            prev = blink;
        end
        if (m_state == 0) check({tag, "_steady_run"}, 32'(blink === 1'b1 && ntr == 0), 1);
        else check({tag, "_toggles"}, 32'(ntr >= 2), 1);
    endtask

    // In AL_H: one inc press, then blink must restart its visible half-period.
    task automatic inc_blink_check();
        logic [5:0] old;
        int waited;
        old = alarm_hours;
        @(negedge clk);
        btn_inc = 1'b1;
        repeat (D) @(negedge clk);
        btn_inc = 1'b0;
        waited = 0;
        while (alarm_hours === old && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (alarm_hours === old) begin
            check("inc_seen_timeout", 0, 1);
        end else begin
            check("inc_blink_restart", 32'(blink), 1);
            repeat (B) @(negedge clk);
            check("inc_blink_half", 32'(blink), 0);
        end
        repeat (D + 6) @(negedge clk);
        model_inc();
        check_op("inc_blink");
    endtask

    initial begin
        rst = 1'b1;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        exp_loads = 0;
        set_cur(0, 0);
        do_reset("reset");

        // 23:59 edited to 00:00 and committed.
        set_cur(23, 59);
        press(1, 0, 5, "t3_mode1");
        press(0, 1, 5, "t3_inc_h");
        press(1, 0, 5, "t3_mode2");
        press(0, 1, 5, "t3_inc_m");
        press(1, 0, 5, "t3_commit");
        check("t3_load_h_zero", 32'(bus.load_hours), 0);
        check("t3_load_m_zero", 32'(bus.load_minutes), 0);
        inc_blink_check();

        // Simultaneous mode+inc in AL_EN, then a full loop to arm the alarm.
        press(1, 0, 5, "t5_to_al_m");
        press(1, 0, 5, "t5_to_al_en");
        press(1, 1, 6, "t5_both");
        for (int i = 0; i < 5; i++) press(1, 0, 5, "t5_loop");
        press(0, 1, 6, "t5_arm");
        check("t5_armed", 32'(alarm_enable), 1);
        press(1, 0, 5, "t5_to_run");

        // Short glitch ignored, longer hold counts once; held inc repeats.
        set_cur(10, 58);
        press(1, 0, 5, "t2_to_set_h");
        press(0, 1, 3, "t2_glitch");
        press(0, 1, 10, "t2_hold");
        press(1, 0, 5, "t4_to_set_m");
        check_blink("t4_blink");
        press(0, 1, 40, "t4_repeat");
        press(1, 0, 5, "t4_commit");
        check("t4_load_h", 32'(bus.load_hours), 11);
        check("t4_load_m", 32'(bus.load_minutes), 1);

        // Reset in the middle of a minute edit.
        for (int i = 0; i < 3; i++) press(1, 0, 5, "t6_to_run");
        press(1, 0, 5, "t6_set_h");
        press(1, 0, 5, "t6_set_m");
        press(0, 1, 5, "t6_inc1");
        press(0, 1, 5, "t6_inc2");
        do_reset("t6_reset");

        for (int k = 0; k < 150; k++) begin
            int r;
            r = $urandom_range(0, 99);
            if (m_state == 0 && $urandom_range(0, 1) == 1)
                set_cur(($urandom_range(0, 9) == 0) ? $urandom_range(24, 63) : $urandom_range(0, 23),
                        ($urandom_range(0, 9) == 0) ? $urandom_range(60, 127) : $urandom_range(0, 59));
            if (r < 40)      press(1, 0, $urandom_range(1, 8), "rnd_mode");
            else if (r < 85) press(0, 1, $urandom_range(1, 40), "rnd_inc");
            else if (r < 95) press(1, 1, $urandom_range(1, R), "rnd_both");
            else             do_reset("rnd_reset");
            if (k % 6 == 0) check_blink("rnd_blink");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
